// File: rtl/four_bank_mem_pkg.sv
// Shared widths and field positions for the four-bank main memory and the
// cache controller that drives it.
//   WORD_W/ADDR_W : data word and byte-address widths
//   BANK field    : Addr[2:1] selects the bank (word interleave)
//   IDX field     : Addr[15:3] selects the word inside a bank
package four_bank_mem_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned BANK_CNT   = 4;
   localparam int unsigned BANK_W     = 2;
   localparam int unsigned BANK_LSB   = 1;
   localparam int unsigned IDX_W      = 13;
   localparam int unsigned IDX_LSB    = 3;
   localparam int unsigned BANK_WORDS = 8192;
   localparam int unsigned BUSY_CYC   = 4;
   localparam int unsigned RD_LAT     = 2;
   localparam int unsigned CNT_W      = 3;

   typedef logic [WORD_W-1:0] word_t;

   // Read request captured in pipeline stage 1
   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [IDX_W-1:0]  idx;
   } rd_req_t;

endpackage

// File: rtl/mem_bank.sv
// One memory bank: word array, write port, registered read port and the
// occupancy counter that holds the bank busy after each accepted access.
//   clk, rst   : clock, asynchronous active-high reset (counter only)
//   acc_i      : a request to this bank is accepted this cycle
//   we_i       : the accepted request is a write
//   widx_i     : word index of the accepted request
//   wdata_i    : write data
//   re_i       : capture the array word at ridx_i into the read register
//   ridx_i     : read word index
//   rdata_o    : registered read data
//   busy_o     : occupancy counter nonzero
module mem_bank
   import four_bank_mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             acc_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  word_t            wdata_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] ridx_i,
   output word_t            rdata_o,
   output logic             busy_o
);

   word_t            mem_q [BANK_WORDS];
   word_t            rdata_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Array and read register carry no reset so contents survive rst
   always_ff @(posedge clk) begin
      if (acc_i && we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[ridx_i];
      end
   end

   // Occupancy: reload on accept, otherwise count down and hold at zero
   always_comb begin
      cnt_d = cnt_q;
      if (acc_i) begin
         cnt_d = CNT_W'(BUSY_CYC - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rdata_o = rdata_q;
   assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Four-bank word-interleaved main memory behind the cache controller.
// One request per cycle, fixed two-cycle read latency, per-bank stall.
//   clk, rst   : clock, asynchronous active-high reset
//   Addr       : byte address (bit 0 must be 0)
//   DataIn     : write data
//   rd, wr     : read / write request, held by the requester until accepted
//   createdump : simulation dump trigger, not used by the hardware
//   DataOut    : read data, zero unless data_vld
//   data_vld   : DataOut valid this cycle
//   stall      : target bank busy, request not accepted (combinational)
//   busy       : per-bank occupancy flags (from counter registers)
//   err        : illegal request this cycle (combinational)
module four_bank_mem
   import four_bank_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   Addr,
   input  logic [WORD_W-1:0]   DataIn,
   input  logic                rd,
   input  logic                wr,
   input  logic                createdump,
   output logic [WORD_W-1:0]   DataOut,
   output logic                data_vld,
   output logic                stall,
   output logic [BANK_CNT-1:0] busy,
   output logic                err
);

   logic              req;
   logic              acc;
   logic [BANK_W-1:0] bank_sel;
   logic [IDX_W-1:0]  idx;
   rd_req_t           s1_q;
   rd_req_t           s1_d;
   logic [BANK_W-1:0] s2_bank_q;
   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] vld_d;
   word_t             bank_rdata [BANK_CNT];
   logic              unused_createdump;

   // Memory dump is a simulation facility; the hardware ignores the trigger
   assign unused_createdump = createdump;

   // Decode, error and stall; an erroneous request never stalls or occupies a bank
   always_comb begin
      bank_sel = Addr[BANK_LSB +: BANK_W];
      idx      = Addr[IDX_LSB +: IDX_W];
      req      = rd | wr;
      err      = (rd & wr) | (req & Addr[0]);
      stall    = req & ~err & busy[bank_sel];
      acc      = req & ~err & ~stall;
      s1_d     = '{bank: bank_sel, idx: idx};
      vld_d    = {vld_q[RD_LAT-2:0], acc & rd};
   end

   for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
      mem_bank u_bank (
         .clk     (clk),
         .rst     (rst),
         .acc_i   (acc && (bank_sel == BANK_W'(b))),
         .we_i    (wr),
         .widx_i  (idx),
         .wdata_i (DataIn),
         .re_i    (vld_q[0] && (s1_q.bank == BANK_W'(b))),
         .ridx_i  (s1_q.idx),
         .rdata_o (bank_rdata[b]),
         .busy_o  (busy[b])
      );
   end

   // Read pipeline: S1 holds the accepted request, S2 selects the bank's read register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= '0;
         s2_bank_q <= '0;
         vld_q     <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_bank_q <= s1_q.bank;
         vld_q     <= vld_d;
      end
   end

   assign data_vld = vld_q[RD_LAT-1];

   always_comb begin
      DataOut = '0;
      if (data_vld) begin
         DataOut = bank_rdata[s2_bank_q];
      end
   end

endmodule

// File: tb/tb_four_bank_mem.sv
module tb_four_bank_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] Addr = '0;
   logic [15:0] DataIn = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        createdump = 1'b0;
   logic [15:0] DataOut;
   logic        data_vld;
   logic        stall;
   logic [3:0]  busy;
   logic        err;

   four_bank_mem dut (
      .clk        (clk),
      .rst        (rst),
      .Addr       (Addr),
      .DataIn     (DataIn),
      .rd         (rd),
      .wr         (wr),
      .createdump (createdump),
      .DataOut    (DataOut),
      .data_vld   (data_vld),
      .stall      (stall),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int unsigned due;
   } exp_t;

   exp_t        sb [$];
   logic [15:0] model [logic [15:0]];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then retire whatever the read port delivers
   task automatic tick();
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
      cyc++;
      if (sb.size() != 0 && sb[0].due < cyc) begin
         chk("vld_missing", 32'(data_vld), 32'd1);
         void'(sb.pop_front());
      end
      if (data_vld) begin
         if (sb.size() == 0) begin
            chk("vld_unexpected", 32'(data_vld), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_data", 32'(DataOut), 32'(e.data));
            chk("rd_cycle", cyc, e.due);
         end
      end else begin
         chk("dout_idle", 32'(DataOut), 32'd0);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) tick();
   endtask

   // Drive one request, check stall/err, and record expectations if accepted
   task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic es, input logic ee, input string tag);
      rd = r;
      wr = w;
      Addr = a;
      DataIn = d;
      #1;
      chk({tag, "_stall"}, 32'(stall), 32'(es));
      chk({tag, "_err"}, 32'(err), 32'(ee));
      if (!es && !ee) begin
         if (w) model[a] = d;
         if (r) sb.push_back('{model[a], cyc + 2});
      end
   endtask

   initial begin
      logic [15:0] pre_a [8];
      logic [15:0] pre_d [8];
      pre_a = '{16'h0100, 16'h0102, 16'h0104, 16'h0106, 16'h0108, 16'h0010, 16'h0300, 16'h0200};
      pre_d = '{16'hA100, 16'hA102, 16'hA104, 16'hA106, 16'hB108, 16'h0F10, 16'h3300, 16'h0000};

      // Reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_vld", 32'(data_vld), 32'd0);
      chk("rst_dout", 32'(DataOut), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // Preload, one write per bank-free interval
      for (int i = 0; i < 8; i++) begin
         req(1'b0, 1'b1, pre_a[i], pre_d[i], 1'b0, 1'b0, "pre");
         tick();
         idle(3);
      end

      // Line fill to four different banks: no stall, one word per cycle in order
      for (int i = 0; i < 4; i++) begin
         chk("t1_busy", 32'(busy), 32'((1 << i) - 1));
         req(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'h0, 1'b0, 1'b0, "t1");
         tick();
      end
      idle(6);

      // Same-bank conflict: stall for three cycles, accept on the fourth
      req(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0, "t2a");
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t2_busy", 32'(busy), 32'h1);
         req(1'b1, 1'b0, 16'h0108, 16'h0, 1'b1, 1'b0, "t2b_hold");
         tick();
      end
      req(1'b1, 1'b0, 16'h0108, 16'h0, 1'b0, 1'b0, "t2b_acc");
      tick();
      idle(6);

      // Read after write returns the new word
      req(1'b0, 1'b1, 16'h0200, 16'hBEEF, 1'b0, 1'b0, "t3w");
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t3_busy", 32'(busy), 32'h1);
         tick();
      end
      chk("t3_busy_free", 32'(busy), 32'h0);
      req(1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 1'b0, "t3r");
      tick();
      idle(6);

      // Illegal requests: dropped, no occupancy, no stall, no data
      req(1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b0, 1'b1, "e_rdwr");
      tick();
      chk("e_rdwr_busy", 32'(busy), 32'h0);
      req(1'b0, 1'b1, 16'h0011, 16'hDEAD, 1'b0, 1'b1, "e_wodd");
      tick();
      chk("e_wodd_busy", 32'(busy), 32'h0);
      req(1'b1, 1'b0, 16'h0011, 16'h0, 1'b0, 1'b1, "e_rodd");
      tick();
      chk("e_rodd_busy", 32'(busy), 32'h0);
      req(1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, "e_fill");
      tick();
      req(1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b0, 1'b1, "e_busybank");
      tick();
      idle(3);
      req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, "e_readback");
      tick();
      idle(6);

      // Reset with a read in flight: it is discarded, counters clear at once
      req(1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, "r_acc");
      void'(sb.pop_back());
      tick();
      rst = 1'b1;
      #1;
      chk("r_busy_async", 32'(busy), 32'h0);
      chk("r_vld_async", 32'(data_vld), 32'd0);
      tick();
      rst = 1'b0;
      idle(5);
      req(1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, "r_readback");
      tick();
      idle(6);

      // Write-back burst followed by line fill of the same line
      for (int i = 0; i < 4; i++) begin
         req(1'b0, 1'b1, 16'h1A00 + 16'(2 * i), 16'hC000 + 16'(i * 16'h0111), 1'b0, 1'b0, "wb");
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         req(1'b1, 1'b0, 16'h1A00 + 16'(2 * i), 16'h0, 1'b0, 1'b0, "fill");
         tick();
      end
      idle(6);

      chk("sb_drain", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
